// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the adder / subtractor family.
package arith_pkg;

    // Operand width shared by the four-bit adder, this subtractor and their benches.
    localparam int ADDER_W = 4;

    // Sequencing states of the bit-serial subtractor.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor_1b.sv
// One-bit full subtractor cell: x - y - bi -> difference bit and borrow out.
module full_subtractor_1b (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic dbit,
    output logic bo
);

    assign dbit = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = {borrow_out, (a-b) mod 2**N}, LSB first,
// one bit per clock, sequenced by a start/done handshake.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int N  = ADDER_W,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N:0]   d
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sub_state_t     r_state;
    sub_state_t     w_next;
    logic           w_accept;
    logic [N-1:0]   r_ra;
    logic [N-1:0]   r_rb;
    logic           r_borrow;
    logic [CW-1:0]  r_cnt;
    // Only the N-1 earlier difference bits are stored; the final bit comes
    // straight from the cell on the last SHIFT edge, so d can load there.
    logic [N-2:0]   r_diff;
    logic [N:0]     r_d;
    logic           w_dbit;
    logic           w_bo;
    logic           w_last;
    logic [N-1:0]   w_diff_cat;

    full_subtractor_1b u_cell (
        .x    (r_ra[0]),
        .y    (r_rb[0]),
        .bi   (r_borrow),
        .dbit (w_dbit),
        .bo   (w_bo)
    );

    assign w_last     = (r_cnt == LAST);
    assign w_diff_cat = {w_dbit, r_diff};
    assign d          = r_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode, start acceptance and status outputs.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, serial shift and result load on the SHIFT->DONE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra     <= '0;
            r_rb     <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_d      <= '0;
        end else if (w_accept) begin
            r_ra     <= a;
            r_rb     <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
        end else if (r_state == SHIFT) begin
            r_ra     <= {1'b0, r_ra[N-1:1]};
            r_rb     <= {1'b0, r_rb[N-1:1]};
            r_borrow <= w_bo;
            r_cnt    <= r_cnt + 1'b1;
            r_diff   <= w_diff_cat[N-1:1];
            if (w_last) r_d <= {w_bo, w_diff_cat};
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: handshake timing, directed vectors,
// back-to-back operation, mid-operation reset and an all-pairs sweep.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N:0]   d;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(N), .CW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Run one operation from IDLE; inputs are scrambled after acceptance.
    task automatic op(input logic [3:0] ia, input logic [3:0] ib,
                      input logic [4:0] exp_d, input string tag, input bit timing);
        int k;
        int nb;
        logic [3:0] s;
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ia; b = ~ib;
        k = 0; nb = 0;
        while (!done && k < 20) begin
            if (busy) nb++;
            @(posedge clk); #1;
            k++;
        end
        if (timing) begin
            chk({tag, "_lat"}, k, N);
            chk({tag, "_busycyc"}, nb, N);
            chk({tag, "_busy_in_done"}, busy, 1'b0);
        end
        chk({tag, "_d"}, d, exp_d);
        s = d[3:0] + ib;
        chk({tag, "_xadd"}, s, ia);
        @(posedge clk); #1;
        if (timing) chk({tag, "_done_once"}, done, 1'b0);
    endtask

    initial begin
        int k;
        logic [4:0] e;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_d", d, 5'b00000);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors (adder bench set, reversed).
        op(4'd0,  4'd0,  5'b00000, "z_z",    1'b1);
        op(4'd0,  4'd1,  5'b11111, "0_1",    1'b1);
        op(4'd0,  4'd15, 5'b10001, "0_15",   1'b1);
        op(4'd15, 4'd15, 5'b00000, "15_15",  1'b1);
        op(4'd1,  4'd15, 5'b10010, "1_15",   1'b1);
        op(4'd15, 4'd0,  5'b01111, "15_0",   1'b1);

        // Back-to-back with start held high.
        a = 4'd9; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (!done && k < 20) begin @(posedge clk); #1; k++; end
        chk("b2b_lat1", k, N);
        chk("b2b_d1", d, 5'b00110);
        @(posedge clk); #1;
        chk("b2b_rebusy", busy, 1'b1);
        chk("b2b_nodone", done, 1'b0);
        a = 4'd2;
        k = 1;
        while (!done && k < 20) begin @(posedge clk); #1; k++; end
        chk("b2b_gap", k, N + 1);
        chk("b2b_d2", d, 5'b00110);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle_busy", busy, 1'b0);
        chk("b2b_idle_done", done, 1'b0);
        chk("b2b_hold_d", d, 5'b00110);

        // Reset during the third SHIFT cycle.
        a = 4'd5; b = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_d", d, 5'b00000);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_quiet", done, 1'b0);
        op(4'd7, 4'd2, 5'b00101, "post_rst", 1'b1);

        // All operand pairs.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                e = 5'(i) - 5'(j);
                op(i[3:0], j[3:0], e, $sformatf("ex_%0d_%0d", i, j), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
